ttt_game_ctrl: RTL and testbench
================================

# ttt_game_ctrl

Game controller for the tic-tac-toe VGA display. It takes debounced button pulses, moves a 3x3 cursor, and alternates turns between two players. It writes the 2-bit-per-cell board, detects wins and draws with a sequential line scanner, and drives the 18-bit board vector and 9-bit cell-highlight vector consumed by the pixel renderer. Display-facing outputs update only on the frame-start pulse, so a frame never shows a half-updated board.

## Interface
- FLASH_FRAMES, 30: frames per blink half-period of the winning-line highlight; legal range 1..255.
- clk  in  1  pixel/system clock.
- reset  in  1  asynchronous, active-high.
- btn_up, btn_down, btn_left, btn_right  in  1 each  single-cycle debounced cursor pulses.
- btn_place  in  1  single-cycle pulse: claim the cell under the cursor.
- btn_restart  in  1  single-cycle pulse: new game.
- frame_start  in  1  single-cycle pulse at vblank start.
- board  out  18  displayed board; cell i = row*3+col occupies bits [2i+1:2i]; 00 empty, 01 player 1, 10 player 2.
- cell_select_flag  out  9  displayed highlight mask; bit i = cell i.
- cur_player  out  1  0 = player 1 to move, 1 = player 2 to move.
- winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw.
- game_over  out  1  high in OVER.
- busy  out  1  high in CHECK.

## Operation
- State machine: PLAY, CHECK, OVER. Reset enters PLAY.
- Internal state:
  - board_int[17:0]
  - cursor row/col (2 bits each, range 0..2)
  - move_cnt (0..9)
  - line_idx (0..7)
  - win_mask[8:0]
  - blink counter and blink phase
- Reset state:
  - board_int = 0, cursor = (1,1), move_cnt = 0, cur_player = 0.
  - Outputs: board = 0, cell_select_flag = 9'h010, winner = 00, game_over = 0, busy = 0, blink phase = 1.
- Input priority within one cycle: restart > place > up > down > left > right. At most one action is taken per cycle.
- Restart is honoured in any state. Next cycle it sets the reset state above, except that board and cell_select_flag still wait for frame_start.
- PLAY, cursor buttons:
  - Up/down decrement/increment the row; left/right decrement/increment the column.
  - Movement wraps: 0 -> 2 going up/left, 2 -> 0 going down/right.
- PLAY, btn_place:
  - Empty cell: write code {cur_player, ~cur_player} into the cell, increment move_cnt, set line_idx = 0, go to CHECK.
  - Occupied cell: ignore the press; nothing changes.
- CHECK: one line per cycle.
  - Line order: 0-2 rows {0,1,2},{3,4,5},{6,7,8}; 3-5 columns {0,3,6},{1,4,7},{2,5,8}; 6 {0,4,8}; 7 {2,4,6}.
  - Match (all three cells equal the current player's code): winner = that code, win_mask = the line's cells, go to OVER.
  - Mismatch on line 7 with move_cnt = 9: winner = 11, win_mask = 0, go to OVER.
  - Mismatch on line 7 otherwise: toggle cur_player, go to PLAY.
  - All non-restart buttons are ignored in CHECK.
- OVER: holds until restart; all other buttons are ignored.
- Highlight source (internal):
  - PLAY/CHECK: one-hot of cursor index.
  - OVER: win_mask when blink phase = 1, else 0.
- Blink: in OVER, each frame_start increments the blink counter. On reaching FLASH_FRAMES-1 the counter clears and blink phase toggles. Counter and phase reset to 0/1 on leaving OVER.

## Timing
- Place pulse at cycle t (cell empty):
  - board_int and move_cnt update at t+1; CHECK is entered at t+1 with line_idx 0.
  - Line k is evaluated in cycle t+1+k.
  - Exit transition lands at t+2+k for a win on line k, or at t+9 with no win.
  - winner, game_over and cur_player are registered in the same edge as the state transition.
- busy = 1 exactly while in CHECK.
- board and cell_select_flag are shadow registers loaded only on cycles where frame_start = 1, from the internal values of that same cycle. Display latency is therefore up to one frame.
- winner, cur_player, game_over and busy are not shadowed.
- A frame_start coinciding with a button press latches the pre-press internal values.
- Reset mid-CHECK or mid-blink aborts immediately; no partial result is kept.

## Test plan
- Reset, then one frame_start -> board = 0, cell_select_flag = 9'h010, cur_player = 0, winner = 00.
- From (1,1): up, up, left, left, then frame_start -> cursor (2,2), cell_select_flag = 9'h100 (wrap both axes).
- Place at cell 4, then place at cell 4 again on player 2's turn -> board[9:8] = 01, second press ignored, cur_player stays 1, move_cnt = 1.
- Player 1 places cells 0, 1, 2 with player 2 moves interleaved -> winner = 01 two cycles after the final place (line 0), game_over = 1. After FLASH_FRAMES frame_starts cell_select_flag toggles between 9'h007 and 0.
- Fill the board with no line (P1: 0, 2, 3, 7, 8; P2: 1, 4, 5, 6) -> winner = 11 nine cycles after the last place, cell_select_flag = 0 in OVER.
- Assert btn_restart and btn_place in the same cycle during CHECK -> restart wins: board_int = 0, state PLAY, busy = 0 next cycle. Board output clears at the next frame_start.

Source files
------------

// File: rtl/ttt_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ttt_game_ctrl
// Description : Tic-tac-toe game controller. Moves a 3x3 cursor, alternates
//               turns, scans the eight lines one per cycle for a win or draw,
//               and publishes board/highlight to the renderer on frame_start.
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_game_ctrl #(
  parameter int FLASH_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_place,
  input  logic        btn_restart,
  input  logic        frame_start,
  output logic [17:0] board,
  output logic [8:0]  cell_select_flag,
  output logic        cur_player,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  // Last blink count before the highlight phase flips.
  localparam logic [7:0] c_flash_last = 8'(FLASH_FRAMES - 1);

  state_t      r_state,       w_state_nxt;
  logic [17:0] r_board_int,   w_board_nxt;
  logic [1:0]  r_row,         w_row_nxt;
  logic [1:0]  r_col,         w_col_nxt;
  logic [3:0]  r_move_cnt,    w_move_cnt_nxt;
  logic [2:0]  r_line_idx,    w_line_idx_nxt;
  logic [8:0]  r_win_mask,    w_win_mask_nxt;
  logic [7:0]  r_blink_cnt,   w_blink_cnt_nxt;
  logic        r_blink_phase, w_blink_phase_nxt;
  logic        r_player,      w_player_nxt;
  logic [1:0]  r_winner,      w_winner_nxt;

  logic [3:0]  w_cur_idx;
  logic [1:0]  w_cur_cell;
  logic [1:0]  w_code;
  logic [8:0]  w_line_mask;
  logic [8:0]  w_cell_eq;
  logic        w_line_match;
  logic [8:0]  w_highlight;

  // Cursor cell index and the mark the current player would write.
  assign w_cur_idx  = ({2'b00, r_row} * 4'd3) + {2'b00, r_col};
  assign w_cur_cell = r_board_int[{w_cur_idx, 1'b0} +: 2];
  assign w_code     = {r_player, ~r_player};

  // Per-cell "holds the current player's mark" flags for the line scanner.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cell
      assign w_cell_eq[gi] = (r_board_int[2*gi +: 2] == w_code);
    end
  endgenerate

  // Cells belonging to the line currently being scanned.
  always_comb begin
    w_line_mask = 9'h000;
    case (r_line_idx)
      3'd0: w_line_mask = 9'h007;
      3'd1: w_line_mask = 9'h038;
      3'd2: w_line_mask = 9'h1C0;
      3'd3: w_line_mask = 9'h049;
      3'd4: w_line_mask = 9'h092;
      3'd5: w_line_mask = 9'h124;
      3'd6: w_line_mask = 9'h111;
      3'd7: w_line_mask = 9'h054;
      default: w_line_mask = 9'h000;
    endcase
  end

  assign w_line_match = &(w_cell_eq | ~w_line_mask);

  // Highlight: cursor while playing, blinking winning line once the game ends.
  always_comb begin
    w_highlight = 9'h000;
    if (r_state == ST_OVER) begin
      w_highlight = r_blink_phase ? r_win_mask : 9'h000;
    end else begin
      w_highlight = 9'h001 << w_cur_idx;
    end
  end

  // Next-state and datapath update; restart overrides everything else.
  always_comb begin
    w_state_nxt       = r_state;
    w_board_nxt       = r_board_int;
    w_row_nxt         = r_row;
    w_col_nxt         = r_col;
    w_move_cnt_nxt    = r_move_cnt;
    w_line_idx_nxt    = r_line_idx;
    w_win_mask_nxt    = r_win_mask;
    w_blink_cnt_nxt   = r_blink_cnt;
    w_blink_phase_nxt = r_blink_phase;
    w_player_nxt      = r_player;
    w_winner_nxt      = r_winner;

    if (btn_restart) begin
      w_state_nxt       = ST_PLAY;
      w_board_nxt       = 18'h00000;
      w_row_nxt         = 2'd1;
      w_col_nxt         = 2'd1;
      w_move_cnt_nxt    = 4'd0;
      w_line_idx_nxt    = 3'd0;
      w_win_mask_nxt    = 9'h000;
      w_blink_cnt_nxt   = 8'd0;
      w_blink_phase_nxt = 1'b1;
      w_player_nxt      = 1'b0;
      w_winner_nxt      = 2'b00;
    end else begin
      case (r_state)
        ST_PLAY: begin
          if (btn_place) begin
            // A press on an occupied cell is swallowed without side effects.
            if (w_cur_cell == 2'b00) begin
              w_board_nxt[{w_cur_idx, 1'b0} +: 2] = w_code;
              w_move_cnt_nxt = r_move_cnt + 4'd1;
              w_line_idx_nxt = 3'd0;
              w_state_nxt    = ST_CHECK;
            end
          end else if (btn_up) begin
            w_row_nxt = (r_row == 2'd0) ? 2'd2 : r_row - 2'd1;
          end else if (btn_down) begin
            w_row_nxt = (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
          end else if (btn_left) begin
            w_col_nxt = (r_col == 2'd0) ? 2'd2 : r_col - 2'd1;
          end else if (btn_right) begin
            w_col_nxt = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;
          end
        end
        ST_CHECK: begin
          if (w_line_match) begin
            w_winner_nxt   = w_code;
            w_win_mask_nxt = w_line_mask;
            w_state_nxt    = ST_OVER;
          end else if (r_line_idx == 3'd7) begin
            if (r_move_cnt == 4'd9) begin
              w_winner_nxt   = 2'b11;
              w_win_mask_nxt = 9'h000;
              w_state_nxt    = ST_OVER;
            end else begin
              w_player_nxt = ~r_player;
              w_state_nxt  = ST_PLAY;
            end
          end else begin
            w_line_idx_nxt = r_line_idx + 3'd1;
          end
        end
        ST_OVER: begin
          if (frame_start) begin
            if (r_blink_cnt == c_flash_last) begin
              w_blink_cnt_nxt   = 8'd0;
              w_blink_phase_nxt = ~r_blink_phase;
            end else begin
              w_blink_cnt_nxt = r_blink_cnt + 8'd1;
            end
          end
        end
        default: w_state_nxt = ST_PLAY;
      endcase
    end
  end

  // Game state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_PLAY;
      r_board_int   <= 18'h00000;
      r_row         <= 2'd1;
      r_col         <= 2'd1;
      r_move_cnt    <= 4'd0;
      r_line_idx    <= 3'd0;
      r_win_mask    <= 9'h000;
      r_blink_cnt   <= 8'd0;
      r_blink_phase <= 1'b1;
      r_player      <= 1'b0;
      r_winner      <= 2'b00;
    end else begin
      r_state       <= w_state_nxt;
      r_board_int   <= w_board_nxt;
      r_row         <= w_row_nxt;
      r_col         <= w_col_nxt;
      r_move_cnt    <= w_move_cnt_nxt;
      r_line_idx    <= w_line_idx_nxt;
      r_win_mask    <= w_win_mask_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_blink_phase <= w_blink_phase_nxt;
      r_player      <= w_player_nxt;
      r_winner      <= w_winner_nxt;
    end
  end

  // Display shadows: sample pre-edge internal values only at vblank start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board            <= 18'h00000;
      cell_select_flag <= 9'h010;
    end else if (frame_start) begin
      board            <= r_board_int;
      cell_select_flag <= w_highlight;
    end
  end

  assign cur_player = r_player;
  assign winner     = r_winner;
  assign game_over  = (r_state == ST_OVER);
  assign busy       = (r_state == ST_CHECK);

endmodule
`default_nettype wire

// File: tb/tb_ttt_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ttt_game_ctrl
// Description : Scoreboard bench for ttt_game_ctrl with a game-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ttt_game_ctrl;

  localparam int c_flash = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        btn_place = 1'b0, btn_restart = 1'b0, frame_start = 1'b0;
  logic [17:0] board;
  logic [8:0]  cell_select_flag;
  logic        cur_player;
  logic [1:0]  winner;
  logic        game_over;
  logic        busy;

  always #5 clk = ~clk;

  ttt_game_ctrl #(.FLASH_FRAMES(c_flash)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_place(btn_place), .btn_restart(btn_restart), .frame_start(frame_start),
    .board(board), .cell_select_flag(cell_select_flag), .cur_player(cur_player),
    .winner(winner), .game_over(game_over), .busy(busy)
  );

  typedef struct {
    logic [17:0] board;
    logic [8:0]  csf;
    logic        player;
    logic [1:0]  winner;
    logic        over;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Game-level model: mode 0 = playing, 1 = judging a move, 2 = finished.
  int   m_cell[9];
  int   m_row, m_col, m_moves, m_player, m_winner, m_mode;
  int   m_remaining, m_result_line, m_over_frames;
  logic [8:0]  m_win_mask;
  logic [17:0] m_sh_board;
  logic [8:0]  m_sh_csf;
  int   c_lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic logic [17:0] m_pack();
    logic [17:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[2*i +: 2] = 2'(m_cell[i]);
    return v;
  endfunction

  function automatic logic [8:0] m_highlight();
    logic [8:0] h;
    h = '0;
    if (m_mode == 2) begin
      if (((m_over_frames / c_flash) % 2) == 0) h = m_win_mask;
    end else begin
      h[m_row*3 + m_col] = 1'b1;
    end
    return h;
  endfunction

  task automatic model_game_reset();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_row = 1; m_col = 1; m_moves = 0; m_player = 0; m_winner = 0;
    m_mode = 0; m_remaining = 0; m_result_line = -1; m_over_frames = 0;
    m_win_mask = '0;
  endtask

  // Decide the whole outcome of a move up front: first completed line wins.
  task automatic plan_check();
    m_result_line = -1;
    for (int k = 0; k < 8; k++) begin
      if (m_result_line < 0 &&
          m_cell[c_lines[k][0]] == m_player + 1 &&
          m_cell[c_lines[k][1]] == m_player + 1 &&
          m_cell[c_lines[k][2]] == m_player + 1)
        m_result_line = k;
    end
    m_remaining = (m_result_line >= 0) ? m_result_line + 1 : 8;
  endtask

  // b = {restart, place, up, down, left, right}
  task automatic model_update(input logic rst, input logic [5:0] b, input logic fs);
    int idx;
    if (rst) begin
      model_game_reset();
      m_sh_board = '0;
      m_sh_csf   = 9'h010;
    end else begin
      if (fs) begin
        m_sh_board = m_pack();
        m_sh_csf   = m_highlight();
      end
      if (b[5]) begin
        model_game_reset();
      end else if (m_mode == 0) begin
        if (b[4]) begin
          idx = m_row*3 + m_col;
          if (m_cell[idx] == 0) begin
            m_cell[idx] = m_player + 1;
            m_moves++;
            plan_check();
            m_mode = 1;
          end
        end else if (b[3]) m_row = (m_row + 2) % 3;
        else if (b[2]) m_row = (m_row + 1) % 3;
        else if (b[1]) m_col = (m_col + 2) % 3;
        else if (b[0]) m_col = (m_col + 1) % 3;
      end else if (m_mode == 1) begin
        m_remaining--;
        if (m_remaining == 0) begin
          if (m_result_line >= 0) begin
            m_winner = m_player + 1;
            m_win_mask = '0;
            for (int j = 0; j < 3; j++) m_win_mask[c_lines[m_result_line][j]] = 1'b1;
            m_mode = 2;
          end else if (m_moves == 9) begin
            m_winner = 3; m_win_mask = '0; m_mode = 2;
          end else begin
            m_player = 1 - m_player; m_mode = 0;
          end
        end
      end else begin
        if (fs) m_over_frames++;
      end
    end
  endtask

  // One clock of stimulus; the model's post-edge view goes to the scoreboard.
  task automatic step(input logic rst, input logic [5:0] b, input logic fs);
    exp_t e;
    @(negedge clk);
    reset = rst;
    {btn_restart, btn_place, btn_up, btn_down, btn_left, btn_right} = b;
    frame_start = fs;
    model_update(rst, b, fs);
    e.board  = m_sh_board;
    e.csf    = m_sh_csf;
    e.player = m_player[0];
    e.winner = 2'(m_winner);
    e.over   = (m_mode == 2);
    e.busy   = (m_mode == 1);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'b000000, 1'b0);
  endtask

  task automatic frame();
    step(1'b0, 6'b000000, 1'b1);
    step(1'b0, 6'b000000, 1'b0);
  endtask

  task automatic goto_cell(input int idx);
    for (int i = 0; i < 3 && m_row != idx / 3; i++) step(1'b0, 6'b000100, 1'b0);
    for (int i = 0; i < 3 && m_col != idx % 3; i++) step(1'b0, 6'b000001, 1'b0);
  endtask

  task automatic place_at(input int idx);
    goto_cell(idx);
    step(1'b0, 6'b010000, 1'b0);
    for (int i = 0; i < 12 && m_mode == 1; i++) idle(1);
  endtask

  task automatic chk(input string name, input logic [17:0] got, input logic [17:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard once per clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("board",      18'(board),            e.board);
        chk("cell_select", 18'(cell_select_flag), 18'(e.csf));
        chk("cur_player",  18'(cur_player),       18'(e.player));
        chk("winner",      18'(winner),           18'(e.winner));
        chk("game_over",   18'(game_over),        18'(e.over));
        chk("busy",        18'(busy),             18'(e.busy));
      end
    end
  end

  initial begin
    int r;
    logic [5:0] b;
    logic fs;
    int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    step(1'b1, 6'b0, 1'b0);
    step(1'b1, 6'b0, 1'b0);
    frame();

    // Cursor wrap on both axes to (2,2).
    step(1'b0, 6'b001000, 1'b0);
    step(1'b0, 6'b001000, 1'b0);
    step(1'b0, 6'b000010, 1'b0);
    step(1'b0, 6'b000010, 1'b0);
    frame();

    // Second press on an occupied centre cell is ignored.
    step(1'b0, 6'b100000, 1'b0);
    place_at(4);
    step(1'b0, 6'b010000, 1'b0);
    idle(3);
    frame();

    // Player 1 wins on row 0, then the highlight blinks.
    step(1'b0, 6'b100000, 1'b0);
    place_at(0); place_at(3); place_at(1); place_at(4); place_at(2);
    for (int i = 0; i < 2*c_flash + 3; i++) frame();

    // Full board, no line: draw.
    step(1'b0, 6'b100000, 1'b0);
    for (int i = 0; i < 9; i++) place_at(draw_seq[i]);
    for (int i = 0; i < 4; i++) frame();

    // Restart beats place in the middle of a line scan.
    step(1'b0, 6'b100000, 1'b0);
    frame();
    step(1'b0, 6'b010000, 1'b0);
    idle(2);
    step(1'b0, 6'b110000, 1'b0);
    idle(1);
    frame();

    // Randomized play.
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       b = 6'b100000;
      else if (r < 28) b = 6'b010000;
      else if (r < 70) b = 6'(1 << $urandom_range(0, 3));
      else if (r < 80) b = 6'($urandom_range(0, 31));
      else             b = 6'b000000;
      fs = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) step(1'b1, b, fs);
      else step(1'b0, b, fs);
    end

    idle(2);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
